// File: rtl/pes_ram_arb_pkg.sv
// Shared types and defaults for the pes_ram_port_arbiter slice.
package pes_ram_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF  = 6;
  localparam int DATA_W_DEF  = 8;
  localparam int PTR_W       = $clog2(NUM_REQ_DEF);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/pes_rr_pick.sv
// Rotating-priority first-one finder: lowest set, unmasked bit at or after start, wrapping.
module pes_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  mask,
  output logic          found,
  output logic [IW-1:0] idx
);
  // Scan from the far end so the closest candidate to start overwrites last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (vec[(int'(start) + k) % N] && !mask[(int'(start) + k) % N]) begin
        found = 1'b1;
        idx   = IW'((int'(start) + k) % N);
      end
    end
  end
endmodule

// File: rtl/pes_ram_port_arbiter.sv
// Two-port round-robin RAM arbiter; optional post-reset RAM zero-fill when
// PES_RAM_ARB_INIT_CLEAR_EN is defined.
import pes_ram_arb_pkg::*;

module pes_ram_port_arbiter #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [NUM_REQ*DATA_W-1:0] rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         ram_addr_a,
  output logic [ADDR_W-1:0]         ram_addr_b,
  output logic [DATA_W-1:0]         ram_data_a,
  output logic [DATA_W-1:0]         ram_data_b,
  output logic                      ram_we_a,
  output logic                      ram_we_b,
  input  logic [DATA_W-1:0]         ram_q_a,
  input  logic [DATA_W-1:0]         ram_q_b
);
  localparam int PW = $clog2(NUM_REQ);

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  state_t              state;
  logic                init_act;
  logic [ADDR_W-1:0]   init_addr;

`ifdef PES_RAM_ARB_INIT_CLEAR_EN
  state_t              state_nxt;
  logic [ADDR_W-2:0]   cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ST_INIT) begin
      cnt_nxt = cnt + 1'b1;
      if (&cnt) state_nxt = ST_RUN;
    end
  end

  assign busy      = rst | (state == ST_INIT);
  assign init_act  = !rst && (state == ST_INIT);
  assign init_addr = {cnt, 1'b0};
`else
  assign state     = ST_RUN;
  assign busy      = 1'b0;
  assign init_act  = 1'b0;
  assign init_addr = '0;
`endif

  logic [PW-1:0]      ptr, idx1, idx2;
  logic               f1, f2, g1, g2, run, conflict;
  logic [ADDR_W-1:0]  a1, a2;
  logic [DATA_W-1:0]  d1, d2;
  logic [NUM_REQ-1:0] mask2;

  assign run   = !rst && (state == ST_RUN);
  assign mask2 = f1 ? (NUM_REQ'(1) << idx1) : '0;

  pes_rr_pick #(.N(NUM_REQ), .IW(PW)) u_pick1 (
    .vec(req), .start(ptr), .mask('0), .found(f1), .idx(idx1)
  );

  // Starting just past pick 1 is the same scan continued, since bits between ptr and pick 1 are clear.
  pes_rr_pick #(.N(NUM_REQ), .IW(PW)) u_pick2 (
    .vec(req), .start(wrap_inc(idx1)), .mask(mask2), .found(f2), .idx(idx2)
  );

  assign a1 = req_addr[int'(idx1)*ADDR_W +: ADDR_W];
  assign a2 = req_addr[int'(idx2)*ADDR_W +: ADDR_W];
  assign d1 = req_wdata[int'(idx1)*DATA_W +: DATA_W];
  assign d2 = req_wdata[int'(idx2)*DATA_W +: DATA_W];

  assign conflict = (a1 == a2) && (req_we[idx1] || req_we[idx2]);
  assign g1 = run && f1;
  assign g2 = run && f1 && f2 && !conflict;

  always_comb begin
    gnt        = '0;
    ram_we_a   = 1'b0;
    ram_we_b   = 1'b0;
    ram_addr_a = '0;
    ram_addr_b = '0;
    ram_data_a = '0;
    ram_data_b = '0;
    if (init_act) begin
      ram_we_a   = 1'b1;
      ram_we_b   = 1'b1;
      ram_addr_a = init_addr;
      ram_addr_b = init_addr | ADDR_W'(1);
    end
    if (g1) begin
      gnt[idx1]  = 1'b1;
      ram_we_a   = req_we[idx1];
      ram_addr_a = a1;
      ram_data_a = req_we[idx1] ? d1 : '0;
    end
    if (g2) begin
      gnt[idx2]  = 1'b1;
      ram_we_b   = req_we[idx2];
      ram_addr_b = a2;
      ram_data_b = req_we[idx2] ? d2 : '0;
    end
  end

  // Per-port owner / read flag, one stage deep to match the RAM read latency.
  logic          rd_a, rd_b;
  logic [PW-1:0] own_a, own_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      rd_a  <= 1'b0;
      rd_b  <= 1'b0;
      own_a <= '0;
      own_b <= '0;
    end else begin
      rd_a  <= g1 && !req_we[idx1];
      rd_b  <= g2 && !req_we[idx2];
      own_a <= idx1;
      own_b <= idx2;
      if (g2)      ptr <= wrap_inc(idx2);
      else if (g1) ptr <= wrap_inc(idx1);
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    logic hit_a, hit_b;
    assign hit_a     = !rst && rd_a && (own_a == PW'(i));
    assign hit_b     = !rst && rd_b && (own_b == PW'(i));
    assign rvalid[i] = hit_a || hit_b;
    assign rdata[i*DATA_W +: DATA_W] = hit_a ? ram_q_a : hit_b ? ram_q_b : '0;
  end
endmodule

// File: tb/tb_pes_ram_port_arbiter.sv
// Scoreboard bench for pes_ram_port_arbiter: directed scenarios then random traffic.
module tb_pes_ram_port_arbiter;
  localparam int N = 4, AW = 6, DW = 8, DEPTH = 64, INIT_CYC = 32;
`ifdef PES_RAM_ARB_INIT_CLEAR_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req, req_we, gnt, rvalid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, rdata;
  logic busy, ram_we_a, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_data_a, ram_data_b, ram_q_a, ram_q_b;

  always #5 clk = ~clk;

  pes_ram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b), .ram_data_a(ram_data_a),
    .ram_data_b(ram_data_b), .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
  );

  // RAM macro model with a preload path used while the design is held in reset.
  logic [DW-1:0] mem [DEPTH];
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  always @(posedge clk) begin
    if (load_en)  mem[load_addr]  <= load_data;
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
    ram_q_a <= mem[ram_addr_a];
    ram_q_b <= mem[ram_addr_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int cyc; logic [N-1:0] gnt; logic busy;
    logic we_a; logic [AW-1:0] addr_a; logic [DW-1:0] d_a;
    logic we_b; logic [AW-1:0] addr_b; logic [DW-1:0] d_b;
  } exp_t;
  typedef struct packed { int cyc; logic [N-1:0] mask; logic [N*DW-1:0] data; } rexp_t;

  exp_t  gq[$];
  rexp_t rq[$];
  int n_tests = 0, n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents this cycle against queued expectations.
  initial begin
    exp_t e;
    rexp_t r;
    forever begin
      @(negedge clk);
      if (gq.size() > 0) begin
        e = gq.pop_front();
        chk("gnt", gnt, e.gnt);
        chk("busy", busy, e.busy);
        chk("port_a", {ram_we_a, ram_addr_a, ram_data_a}, {e.we_a, e.addr_a, e.d_a});
        chk("port_b", {ram_we_b, ram_addr_b, ram_data_b}, {e.we_b, e.addr_b, e.d_b});
        if (rq.size() > 0 && rq[0].cyc <= cyc) begin
          r = rq.pop_front();
          chk("rvalid", rvalid, r.mask);
          chk("rdata", rdata, r.data);
        end else begin
          chk("rvalid_idle", rvalid, '0);
          chk("rdata_idle", rdata, '0);
        end
      end
    end
  end

  // Reference model state: pending requests, rotating pointer, shadow memory.
  logic [N-1:0]  pend = '0, pwe = '0;
  logic [AW-1:0] paddr [N];
  logic [DW-1:0] pdata [N];
  logic [DW-1:0] shadow [DEPTH];
  int ptr_m = 0, init_left = 0;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]                   = pend[i];
      req_we[i]                = pwe[i];
      req_addr[i*AW +: AW]     = paddr[i];
      req_wdata[i*DW +: DW]    = pdata[i];
    end
  endtask

  task automatic step();
    exp_t e;
    rexp_t r;
    int p1, p2, k1;
    e = '0;
    e.cyc = cyc;
    if (rst) begin
      ptr_m  = 0;
      e.busy = FEAT;
      if (FEAT) init_left = INIT_CYC;
      while (rq.size() > 0 && rq[$].cyc >= cyc) void'(rq.pop_back());
    end else if (init_left > 0) begin
      e.busy   = 1'b1;
      e.we_a   = 1'b1;
      e.we_b   = 1'b1;
      e.addr_a = AW'(2 * (INIT_CYC - init_left));
      e.addr_b = AW'(2 * (INIT_CYC - init_left) + 1);
      init_left--;
      if (init_left == 0)
        for (int a = 0; a < DEPTH; a++) shadow[a] = '0;
    end else begin
      p1 = -1; p2 = -1; k1 = 0;
      for (int k = 0; k < N; k++)
        if (p1 < 0 && pend[(ptr_m + k) % N]) begin p1 = (ptr_m + k) % N; k1 = k; end
      if (p1 >= 0)
        for (int k = k1 + 1; k < N; k++)
          if (p2 < 0 && pend[(ptr_m + k) % N]) p2 = (ptr_m + k) % N;
      if (p2 >= 0 && paddr[p1] == paddr[p2] && (pwe[p1] || pwe[p2])) p2 = -1;
      r = '0;
      r.cyc = cyc + 1;
      if (p1 >= 0) begin
        e.gnt[p1] = 1'b1; e.we_a = pwe[p1]; e.addr_a = paddr[p1];
        e.d_a = pwe[p1] ? pdata[p1] : '0;
        if (!pwe[p1]) begin r.mask[p1] = 1'b1; r.data[p1*DW +: DW] = shadow[paddr[p1]]; end
      end
      if (p2 >= 0) begin
        e.gnt[p2] = 1'b1; e.we_b = pwe[p2]; e.addr_b = paddr[p2];
        e.d_b = pwe[p2] ? pdata[p2] : '0;
        if (!pwe[p2]) begin r.mask[p2] = 1'b1; r.data[p2*DW +: DW] = shadow[paddr[p2]]; end
      end
      if (p1 >= 0 && pwe[p1]) shadow[paddr[p1]] = pdata[p1];
      if (p2 >= 0 && pwe[p2]) shadow[paddr[p2]] = pdata[p2];
      if (r.mask != '0) rq.push_back(r);
      if (p2 >= 0)      ptr_m = (p2 + 1) % N;
      else if (p1 >= 0) ptr_m = (p1 + 1) % N;
      if (p1 >= 0) pend[p1] = 1'b0;
      if (p2 >= 0) pend[p2] = 1'b0;
    end
    gq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic we, int addr, int data);
    pend[i] = 1'b1; pwe[i] = we; paddr[i] = AW'(addr); pdata[i] = DW'(data);
  endtask

  task automatic drain(int budget);
    int b = 0;
    while (pend != '0 && b < budget) begin drive(); step(); b++; end
    n_tests++;
    if (pend != '0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%b expected=0", pend);
    end
    drive(); step();
    drive(); step();
  endtask

  task automatic pulse_reset();
    rst = 1'b1; drive(); step(); rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin paddr[i] = '0; pdata[i] = '0; end
    drive();
    @(posedge clk);
    #1;
    // Preload RAM and shadow while reset holds the arbiter idle.
    for (int a = 0; a < DEPTH; a++) begin
      load_en   = 1'b1;
      load_addr = AW'(a);
      load_data = (a == 5) ? 8'hA5 : DW'($urandom);
      shadow[a] = load_data;
      step();
    end
    load_en = 1'b0;
    rst = 1'b0;

    // Release with all requesters active: zero-fill window first when enabled.
    if (FEAT) begin
      for (int i = 0; i < N; i++) set_req(i, 1'b0, i * 17 + 3, 0);
      drain(INIT_CYC + 10);
    end

    set_req(0, 1'b0, 5, 0);
    drain(INIT_CYC + 10);

    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) set_req(i, 1'b0, 10 + i, 0);
      drive(); step();
    end
    drain(INIT_CYC + 10);

    set_req(0, 1'b1, 9, 8'h3C);
    set_req(1, 1'b0, 9, 0);
    drain(INIT_CYC + 10);

    set_req(2, 1'b0, 7, 0);
    set_req(3, 1'b0, 7, 0);
    drain(INIT_CYC + 10);

    // Reset right after a read grant: its response must be dropped.
    set_req(0, 1'b0, 20, 0);
    drive(); step();
    pulse_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 30 + i, 0);
    drain(INIT_CYC + 10);

    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 99) < 55)
          set_req(i, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                               : int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 255)));
      drive(); step();
    end
    rst = 1'b0;
    drain(INIT_CYC + 20);

    chk("rq_empty", 64'(rq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
